// File: rtl/vga_sync_if.sv
// rtl/vga_sync_if.sv - raster timing bundle from vga_sync to vga_display (optional end_frame: VGA_SYNC_FRAME_PULSE_EN)
interface vga_sync_if;
    logic       new_pxl;
    logic [9:0] col;
    logic [9:0] row;
    logic       visible;
    logic       hsync;
    logic       vsync;
`ifdef VGA_SYNC_FRAME_PULSE_EN
    logic       end_frame;

    modport master (output new_pxl, col, row, visible, hsync, vsync, end_frame);
    modport slave  (input  new_pxl, col, row, visible, hsync, vsync, end_frame);
`else
    modport master (output new_pxl, col, row, visible, hsync, vsync);
    modport slave  (input  new_pxl, col, row, visible, hsync, vsync);
`endif
endinterface

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA raster timing generator with pixel-rate enable (optional frame pulse: VGA_SYNC_FRAME_PULSE_EN)
module vga_sync #(
    parameter bit c_synch_act    = 1'b0,
    parameter int c_clk_div      = 4,
    parameter int c_pxl_visible  = 640,
    parameter int c_pxl_fporch   = 16,
    parameter int c_pxl_synch    = 96,
    parameter int c_pxl_bporch   = 48,
    parameter int c_line_visible = 480,
    parameter int c_line_fporch  = 10,
    parameter int c_line_synch   = 2,
    parameter int c_line_bporch  = 33
) (
    input  logic       clk,
    input  logic       rst,
    vga_sync_if.master vga
);
    localparam int C_PXL_TOTAL  = c_pxl_visible + c_pxl_fporch + c_pxl_synch + c_pxl_bporch;
    localparam int C_LINE_TOTAL = c_line_visible + c_line_fporch + c_line_synch + c_line_bporch;
    localparam int C_DIV_W      = (c_clk_div > 1) ? $clog2(c_clk_div) : 1;

    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(c_clk_div - 1);
    localparam logic [9:0] C_COL_LAST  = 10'(C_PXL_TOTAL - 1);
    localparam logic [9:0] C_ROW_LAST  = 10'(C_LINE_TOTAL - 1);
    localparam logic [9:0] C_COL_VIS   = 10'(c_pxl_visible);
    localparam logic [9:0] C_ROW_VIS   = 10'(c_line_visible);
    localparam logic [9:0] C_HS_START  = 10'(c_pxl_visible + c_pxl_fporch);
    localparam logic [9:0] C_HS_END    = 10'(c_pxl_visible + c_pxl_fporch + c_pxl_synch);
    localparam logic [9:0] C_VS_START  = 10'(c_line_visible + c_line_fporch);
    localparam logic [9:0] C_VS_END    = 10'(c_line_visible + c_line_fporch + c_line_synch);

    logic [C_DIV_W-1:0] div_q, div_d;
    logic               new_pxl_q, new_pxl_d;
    logic [9:0]         col_q, col_d;
    logic [9:0]         row_q, row_d;
    logic               visible_q, visible_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
`ifdef VGA_SYNC_FRAME_PULSE_EN
    logic               end_frame_q, end_frame_d;
`endif

    // Next-state: divider, raster counters, and decodes taken from the next col/row so they stay aligned
    always_comb begin
        div_d     = (div_q == C_DIV_LAST) ? '0 : div_q + 1'b1;
        new_pxl_d = (div_d == C_DIV_LAST);
        col_d     = col_q;
        row_d     = row_q;
        if (new_pxl_q) begin
            if (col_q == C_COL_LAST) begin
                col_d = '0;
                row_d = (row_q == C_ROW_LAST) ? '0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
        visible_d = (col_d < C_COL_VIS) && (row_d < C_ROW_VIS);
        hsync_d   = ((col_d >= C_HS_START) && (col_d < C_HS_END)) ? c_synch_act : ~c_synch_act;
        vsync_d   = ((row_d >= C_VS_START) && (row_d < C_VS_END)) ? c_synch_act : ~c_synch_act;
`ifdef VGA_SYNC_FRAME_PULSE_EN
        // Fires in the last clk of the last pixel of the frame, alongside its new_pxl
        end_frame_d = new_pxl_d && (col_d == C_COL_LAST) && (row_d == C_ROW_LAST);
`endif
    end

    // State and registered outputs; reset returns the raster to the top-left pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= '0;
            new_pxl_q   <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            visible_q   <= 1'b1;
            hsync_q     <= ~c_synch_act;
            vsync_q     <= ~c_synch_act;
`ifdef VGA_SYNC_FRAME_PULSE_EN
            end_frame_q <= 1'b0;
`endif
        end else begin
            div_q       <= div_d;
            new_pxl_q   <= new_pxl_d;
            col_q       <= col_d;
            row_q       <= row_d;
            visible_q   <= visible_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
`ifdef VGA_SYNC_FRAME_PULSE_EN
            end_frame_q <= end_frame_d;
`endif
        end
    end

    assign vga.new_pxl   = new_pxl_q;
    assign vga.col       = col_q;
    assign vga.row       = row_q;
    assign vga.visible   = visible_q;
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
`ifdef VGA_SYNC_FRAME_PULSE_EN
    assign vga.end_frame = end_frame_q;
`endif
endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - randomized-length checks of vga_sync against an arithmetic raster model
module tb_vga_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   e = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Three configurations: defaults, divide-by-1 tiny raster, divide-by-3 with active-high sync
    int cfg_div [3] = '{4, 1, 3};
    int cfg_hv  [3] = '{640, 8, 20};
    int cfg_hf  [3] = '{16, 1, 3};
    int cfg_hs  [3] = '{96, 2, 5};
    int cfg_hb  [3] = '{48, 1, 4};
    int cfg_lv  [3] = '{480, 4, 10};
    int cfg_lf  [3] = '{10, 1, 2};
    int cfg_ls  [3] = '{2, 1, 3};
    int cfg_lb  [3] = '{33, 1, 4};
    bit cfg_act [3] = '{1'b0, 1'b0, 1'b1};

    vga_sync_if if_a ();
    vga_sync_if if_b ();
    vga_sync_if if_c ();

    vga_sync u_a (.clk(clk), .rst(rst_n), .vga(if_a));

    vga_sync #(
        .c_synch_act(1'b0), .c_clk_div(1),
        .c_pxl_visible(8), .c_pxl_fporch(1), .c_pxl_synch(2), .c_pxl_bporch(1),
        .c_line_visible(4), .c_line_fporch(1), .c_line_synch(1), .c_line_bporch(1)
    ) u_b (.clk(clk), .rst(rst_n), .vga(if_b));

    vga_sync #(
        .c_synch_act(1'b1), .c_clk_div(3),
        .c_pxl_visible(20), .c_pxl_fporch(3), .c_pxl_synch(5), .c_pxl_bporch(4),
        .c_line_visible(10), .c_line_fporch(2), .c_line_synch(3), .c_line_bporch(4)
    ) u_c (.clk(clk), .rst(rst_n), .vga(if_c));

    // Expected {end_frame, new_pxl, col, row, visible, hsync, vsync} after ev clk edges since reset release
    function automatic logic [24:0] model(input int ev, input int k);
        int div, pt, lt, n, c, r;
        logic np, vis, hs, vs, ef;
        div = cfg_div[k];
        pt  = cfg_hv[k] + cfg_hf[k] + cfg_hs[k] + cfg_hb[k];
        lt  = cfg_lv[k] + cfg_lf[k] + cfg_ls[k] + cfg_lb[k];
        if (ev == 0) begin
            np = 1'b0;
            n  = 0;
        end else begin
            np = ((ev % div) == div - 1);
            n  = (div == 1) ? ev - 1 : ev / div;
        end
        c   = n % pt;
        r   = (n / pt) % lt;
        vis = (c < cfg_hv[k]) && (r < cfg_lv[k]);
        hs  = (c >= cfg_hv[k] + cfg_hf[k] && c < cfg_hv[k] + cfg_hf[k] + cfg_hs[k]) ? cfg_act[k] : !cfg_act[k];
        vs  = (r >= cfg_lv[k] + cfg_lf[k] && r < cfg_lv[k] + cfg_lf[k] + cfg_ls[k]) ? cfg_act[k] : !cfg_act[k];
        ef  = np && (c == pt - 1) && (r == lt - 1);
`ifndef VGA_SYNC_FRAME_PULSE_EN
        ef  = 1'b0;
`endif
        return {ef, np, c[9:0], r[9:0], vis, hs, vs};
    endfunction

    task automatic chk(input string tag, input logic [24:0] o, input logic [24:0] x);
        n_cmp++;
        assert (o === x) else begin
            n_bad++;
            $error("FAIL %s e=%0d observed=%h expected=%h", tag, e, o, x);
        end
    endtask

    task automatic check_all(input string step);
        logic ef_a, ef_b, ef_c;
`ifdef VGA_SYNC_FRAME_PULSE_EN
        ef_a = if_a.end_frame;
        ef_b = if_b.end_frame;
        ef_c = if_c.end_frame;
`else
        ef_a = 1'b0;
        ef_b = 1'b0;
        ef_c = 1'b0;
`endif
        chk({step, "_dflt"}, {ef_a, if_a.new_pxl, if_a.col, if_a.row, if_a.visible, if_a.hsync, if_a.vsync}, model(e, 0));
        chk({step, "_div1"}, {ef_b, if_b.new_pxl, if_b.col, if_b.row, if_b.visible, if_b.hsync, if_b.vsync}, model(e, 1));
        chk({step, "_div3"}, {ef_c, if_c.new_pxl, if_c.col, if_c.row, if_c.visible, if_c.hsync, if_c.vsync}, model(e, 2));
    endtask

    task automatic run(input int cycles, input string step);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            check_all(step);
        end
    endtask

    // Reset mid-cycle without waiting for an edge, hold a few clks, release on a falling edge
    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        #1;
        e = 0;
        check_all("async_rst");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_all("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        e = 0;
        repeat (3) begin
            @(negedge clk);
            check_all("reset");
        end
        rst_n = 1'b1;
        run(6400 + int'($urandom_range(0, 300)), "lines");
        async_reset(int'($urandom_range(1, 5)));
        run(4000 + int'($urandom_range(0, 600)), "frames");
        async_reset(int'($urandom_range(1, 5)));
        run(1500 + int'($urandom_range(0, 400)), "restart");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
